// File: rtl/yuv2rgb_pkg.sv
// rtl/yuv2rgb_pkg.sv - shared constants, FSM states and clamp helper for yuv2rgb_iter
package yuv2rgb_pkg;

  localparam int DEF_BITS = 9;
  localparam int DEF_ACCW = 18;
  localparam int DEF_FRAC = 7;
  localparam int OFFSET   = 128;

  // Q2.7 coefficients, scaled by 128
  localparam logic signed [8:0] CRV = 9'sd179;
  localparam logic signed [8:0] CGU = 9'sd44;
  localparam logic signed [8:0] CGV = 9'sd91;
  localparam logic signed [8:0] CBU = 9'sd227;

  typedef enum logic [2:0] {IDLE, OFFS, M0, M1, M2, M3, OUT} state_t;

  function automatic logic [7:0] clamp8(input int v);
    if (v < 0) return 8'd0;
    else if (v > 255) return 8'd255;
    else return v[7:0];
  endfunction

endpackage

// File: rtl/yuv2rgb_ctrl.sv
// rtl/yuv2rgb_ctrl.sv - sequencing FSM for the shared-multiplier YUV to RGB converter
module yuv2rgb_ctrl
  import yuv2rgb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       capture,
  output logic       acc_load,
  output logic       mac_en,
  output logic [1:0] step,
  output logic       out_load,
  output logic       busy,
  output logic       done
);

  state_t state;

  assign capture = start && (state == IDLE);

  // Strobes are registered one state ahead so they are aligned with the state they serve.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      acc_load <= 1'b0;
      mac_en   <= 1'b0;
      step     <= 2'd0;
      out_load <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      acc_load <= 1'b0;
      mac_en   <= 1'b0;
      out_load <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= OFFS;
          busy     <= 1'b1;
          acc_load <= 1'b1;
        end
        OFFS: begin state <= M0; mac_en <= 1'b1; step <= 2'd0; end
        M0:   begin state <= M1; mac_en <= 1'b1; step <= 2'd1; end
        M1:   begin state <= M2; mac_en <= 1'b1; step <= 2'd2; end
        M2:   begin state <= M3; mac_en <= 1'b1; step <= 2'd3; end
        M3:   begin state <= OUT; busy <= 1'b0; out_load <= 1'b1; end
        OUT:  begin state <= IDLE; done <= 1'b1; end
        default: begin state <= IDLE; busy <= 1'b0; end
      endcase
    end
  end

endmodule

// File: rtl/yuv2rgb_iter.sv
// rtl/yuv2rgb_iter.sv - iterative YUV to RGB converter, one shared multiplier per pixel
module yuv2rgb_iter
  import yuv2rgb_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int ACCW = DEF_ACCW,
  parameter int FRAC = DEF_FRAC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [BITS-1:0] inportY,
  input  logic [BITS-1:0] inportU,
  input  logic [BITS-1:0] inportV,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] outportR,
  output logic [BITS-1:0] outportG,
  output logic [BITS-1:0] outportB
);

  logic                   capture, acc_load, mac_en, out_load;
  logic [1:0]             step;
  logic [BITS-1:0]        y_r, u_r, v_r;
  logic signed [BITS-1:0] du, dv, mul_a;
  logic signed [8:0]      mul_c;
  logic signed [ACCW-1:0] acc_r, acc_g, acc_b, prod, base;

  yuv2rgb_ctrl u_ctrl (
    .clk(clk), .reset(reset), .start(start), .capture(capture),
    .acc_load(acc_load), .mac_en(mac_en), .step(step),
    .out_load(out_load), .busy(busy), .done(done)
  );

  always_comb begin
    mul_a = dv;
    mul_c = CRV;
    case (step)
      2'd0: begin mul_a = dv; mul_c = CRV; end
      2'd1: begin mul_a = du; mul_c = CGU; end
      2'd2: begin mul_a = dv; mul_c = CGV; end
      2'd3: begin mul_a = du; mul_c = CBU; end
      default: ;
    endcase
  end

  assign prod = ACCW'(mul_a) * ACCW'(mul_c);
  // Luma in Q.7 plus half an LSB so the final arithmetic shift rounds to nearest.
  assign base = (ACCW'(y_r) << FRAC) + (ACCW'(1) << (FRAC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_r <= '0; u_r <= '0; v_r <= '0;
      du <= '0; dv <= '0;
      acc_r <= '0; acc_g <= '0; acc_b <= '0;
      outportR <= '0; outportG <= '0; outportB <= '0;
    end else begin
      if (capture) begin
        y_r <= inportY;
        u_r <= inportU;
        v_r <= inportV;
      end
      if (acc_load) begin
        du    <= $signed(u_r - BITS'(OFFSET));
        dv    <= $signed(v_r - BITS'(OFFSET));
        acc_r <= base;
        acc_g <= base;
        acc_b <= base;
      end
      if (mac_en) begin
        case (step)
          2'd0: acc_r <= acc_r + prod;
          2'd1: acc_g <= acc_g - prod;
          2'd2: acc_g <= acc_g - prod;
          2'd3: acc_b <= acc_b + prod;
          default: ;
        endcase
      end
      if (out_load) begin
        outportR <= BITS'(clamp8(int'(acc_r >>> FRAC)));
        outportG <= BITS'(clamp8(int'(acc_g >>> FRAC)));
        outportB <= BITS'(clamp8(int'(acc_b >>> FRAC)));
      end
    end
  end

endmodule

// File: tb/tb_yuv2rgb_iter.sv
// tb/tb_yuv2rgb_iter.sv - self-checking bench for yuv2rgb_iter
module tb_yuv2rgb_iter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [8:0] inportY = '0, inportU = '0, inportV = '0;
  logic       busy, done;
  logic [8:0] outportR, outportG, outportB;

  int n_cmp = 0;
  int n_err = 0;

  yuv2rgb_iter dut (
    .clk(clk), .reset(reset), .start(start),
    .inportY(inportY), .inportU(inportU), .inportV(inportV),
    .busy(busy), .done(done),
    .outportR(outportR), .outportG(outportG), .outportB(outportB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic void ref_px(input int y, input int u, input int v,
                                 output int r, output int g, output int b);
    int base, du, dv;
    base = y * 128 + 64;
    du = u - 128;
    dv = v - 128;
    r = clampi((base + 179 * dv) >>> 7);
    g = clampi((base - 44 * du - 91 * dv) >>> 7);
    b = clampi((base + 227 * du) >>> 7);
  endfunction

  // Reference: a request is accepted when idle, result appears 6 edges later,
  // the unit is free again from the 7th edge, busy covers the first 5 cycles.
  int cyc = 0;
  int acc_cyc = -100;
  int pr = 0, pg = 0, pb = 0;
  int er = 0, eg = 0, eb = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cyc = -100;
      er = 0; eg = 0; eb = 0;
    end else begin
      cyc++;
      if (cyc == acc_cyc + 6) begin
        er = pr; eg = pg; eb = pb;
      end
      if (start && cyc >= acc_cyc + 7) begin
        acc_cyc = cyc;
        ref_px(int'(inportY), int'(inportU), int'(inportV), pr, pg, pb);
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, (cyc >= acc_cyc) && (cyc <= acc_cyc + 4));
    chk("done", done, cyc == acc_cyc + 6);
    chk("R", outportR, er);
    chk("G", outportG, eg);
    chk("B", outportB, eb);
  end

  task automatic pixel(input int y, input int u, input int v,
                       input int xr, input int xg, input int xb, input string nm);
    int lat, nb;
    bit seen;
    inportY = 9'(y); inportU = 9'(u); inportV = 9'(v);
    start = 1'b1;
    lat = 0; nb = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (busy) nb++;
      if (done) seen = 1;
    end
    chk({nm, "_seen"}, seen, 1);
    chk({nm, "_lat"}, lat - 1, 6);
    chk({nm, "_busy"}, nb, 5);
    chk({nm, "_R"}, outportR, xr);
    chk({nm, "_G"}, outportG, xg);
    chk({nm, "_B"}, outportB, xb);
  endtask

  initial begin
    int r, g, b, nd;

    ref_px(128, 128, 128, r, g, b);
    chk("m_grey", {r[7:0], g[7:0], b[7:0]}, {8'd128, 8'd128, 8'd128});
    ref_px(255, 128, 255, r, g, b);
    chk("m_upper", {r[7:0], g[7:0], b[7:0]}, {8'd255, 8'd165, 8'd255});
    ref_px(0, 0, 0, r, g, b);
    chk("m_lower", {r[7:0], g[7:0], b[7:0]}, {8'd0, 8'd135, 8'd0});
    ref_px(100, 200, 50, r, g, b);
    chk("m_mixed", {r[7:0], g[7:0], b[7:0]}, {8'd0, 8'd131, 8'd228});

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rgb", {outportR, outportG, outportB}, 27'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    pixel(128, 128, 128, 128, 128, 128, "grey");
    @(posedge clk); #1;
    pixel(255, 128, 255, 255, 165, 255, "upper");
    @(posedge clk); #1;
    pixel(0, 0, 0, 0, 135, 0, "lower");
    @(posedge clk); #1;
    pixel(100, 200, 50, 0, 131, 228, "mixed");
    pixel(128, 128, 128, 128, 128, 128, "b2b");
    @(posedge clk); #1;

    // start again during M1 with other inputs: must be ignored
    inportY = 9'd255; inportU = 9'd128; inportV = 9'd255;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    inportY = 9'd0; inportU = 9'd0; inportV = 9'd0;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) nd++;
      @(posedge clk); #1;
    end
    chk("busy_ign_ndone", nd, 1);
    chk("busy_ign_rgb", {outportR, outportG, outportB}, {9'd255, 9'd165, 9'd255});

    // reset while in M2
    inportY = 9'd128; inportU = 9'd128; inportV = 9'd128;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rgb", {outportR, outportG, outportB}, 27'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    pixel(128, 128, 128, 128, 128, 128, "after_abort");

    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      inportY = 9'($urandom_range(0, 255));
      inportU = 9'($urandom_range(0, 255));
      inportV = 9'($urandom_range(0, 255));
    end
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
